otter_pc_unit: RTL and testbench
================================

OTTER_PC_UNIT -- requirements
Module: otter_pc_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width in bits (legal: 32 or 64).
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 advance  input  1  PC update enable; low = stall, all state held.
REQ-007 pc_sel  input  3  0 seq, 1 jal, 2 branch, 3 jalr, 4 trap, 5 mret; 6/7 treated as seq.
REQ-008 br_taken  input  1  branch condition result, used only when pc_sel=2.
REQ-009 rs1, i_imm, b_imm, j_imm  input  XLEN each  operand and sign-extended immediates.
REQ-010 mtvec, mepc  input  XLEN each  trap vector and exception return address.
REQ-011 is_call, is_ret  input  1 each  RAS push / pop qualifiers from decode.
REQ-012 misalign_ack  input  1  clears the misalignment flag.
REQ-013 pc  output  XLEN  current PC, registered.
REQ-014 pc_plus4  output  XLEN  pc + 4, combinational from pc.
REQ-015 misalign  output  1  sticky misaligned-target flag, registered.
REQ-016 bad_addr  output  XLEN  offending target captured with misalign.
REQ-017 ras_top  output  XLEN  predicted return address (top entry); 0 when empty.
REQ-018 ras_empty  output  1  high when RAS holds no entries.

Function
REQ-019 Targets: jal = pc+j_imm; branch = pc+b_imm; jalr = (rs1+i_imm) with bit 0 forced 0; all sums modulo 2^XLEN, carry discarded.
REQ-020 Next PC: seq -> pc+4; jal -> jal target; branch -> branch target if br_taken else pc+4; jalr -> jalr target; trap -> {mtvec[XLEN-1:2],2'b00}; mret -> mepc.
REQ-021 When advance=1, pc loads next PC on the clock edge (latency one cycle); when advance=0, pc, RAS, misalign and bad_addr hold regardless of other inputs.
REQ-022 Misaligned check applies to jal, taken branch and jalr targets only; on violation with advance=1: pc still loads target, misalign sets, bad_addr captures target.
REQ-023 While misalign=1, further violations do not overwrite bad_addr; misalign_ack clears misalign next edge; ack and new violation in the same cycle -> flag stays set, bad_addr takes the new target.
REQ-024 RAS push (advance=1, is_call=1, pc_sel 1 or 3): write pc+4 at top; full -> overwrite oldest entry (circular), count saturates at RAS_DEPTH.
REQ-025 RAS pop (advance=1, is_ret=1, pc_sel=3): remove top; empty -> no change, ras_empty stays 1.
REQ-026 is_call and is_ret both high: pop then push in the same edge (net count unchanged; top replaced by pc+4); on empty, behaves as push only.
REQ-027 Trap and mret never touch the RAS.

Reset
REQ-028 rst_n low asynchronously forces pc=RESET_VEC, misalign=0, bad_addr=0, RAS count=0 (ras_empty=1, ras_top=0), regardless of advance or clock.
REQ-029 Reset release takes effect on the first rising edge with rst_n high; no update on the release edge itself other than normal operation.

Configuration
REQ-030 Macro OTTER_RVC_EN defined: alignment unit is 2 bytes; violation = target bit 0 set.
REQ-031 OTTER_RVC_EN undefined: alignment unit is 4 bytes; violation = target bits [1:0] non-zero; jalr target with bit 1 set therefore flags misalign.

Verification
REQ-032 Reset: RESET_VEC=0x100, assert rst_n low mid-cycle -> pc=0x100, misalign=0, ras_empty=1 immediately, before next edge.
REQ-033 Seq/stall: pc=0x100, pc_sel=0, advance 1,0,1 -> pc 0x104, 0x104, 0x108.
REQ-034 jalr: rs1=0x2001, i_imm=0x10, pc_sel=3 -> pc=0x2010, misalign=0; rs1=0x2003 (RVC off) -> pc=0x2012, misalign=1, bad_addr=0x2012.
REQ-035 Branch: pc=0x200, b_imm=-8, br_taken=1 -> 0x1F8; br_taken=0 -> 0x204; wrap: pc=0xFFFFFFFC, pc_sel=0 -> 0x0.
REQ-036 RAS (depth 4): five calls from pc 0x10,0x20,0x30,0x40,0x50 -> ras_top=0x54; four returns -> tops 0x44,0x34,0x24, then empty; fifth return -> no change.
REQ-037 Ack race: misalign=1, misalign_ack=1 with new violating jalr -> misalign stays 1, bad_addr updated.

Source files
------------

// File: rtl/otter_pc_unit.sv
// Program-counter unit: next-PC selection, sticky misaligned-target capture and
// a circular return-address stack. Define OTTER_RVC_EN for 2-byte alignment.
module otter_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic [2:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            misalign_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_JAL  = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_JALR = 3'd3;
  localparam logic [2:0] SEL_TRAP = 3'd4;
  localparam logic [2:0] SEL_MRET = 3'd5;

  localparam logic [XLEN-1:0] FOUR   = XLEN'(4);
  localparam logic [XLEN-1:0] MASK_1 = ~XLEN'(1);
  localparam logic [XLEN-1:0] MASK_3 = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic [XLEN-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] jal_tgt, br_tgt, jalr_tgt, trap_tgt;
  logic [XLEN-1:0] next_pc;
  logic            tgt_checked;
  logic            viol;
  logic            ras_push, ras_pop;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign pc_plus4 = pc_q + FOUR;
  assign jal_tgt  = pc_q + j_imm;
  assign br_tgt   = pc_q + b_imm;
  assign jalr_tgt = (rs1 + i_imm) & MASK_1;
  assign trap_tgt = mtvec & MASK_3;

  always_comb begin
    next_pc     = pc_plus4;
    tgt_checked = 1'b0;
    case (pc_sel)
      SEL_JAL: begin
        next_pc     = jal_tgt;
        tgt_checked = 1'b1;
      end
      SEL_BR: begin
        if (br_taken) begin
          next_pc     = br_tgt;
          tgt_checked = 1'b1;
        end
      end
      SEL_JALR: begin
        next_pc     = jalr_tgt;
        tgt_checked = 1'b1;
      end
      SEL_TRAP: next_pc = trap_tgt;
      SEL_MRET: next_pc = mepc;
      default:  next_pc = pc_plus4;
    endcase
  end

`ifdef OTTER_RVC_EN
  assign viol = tgt_checked & next_pc[0];
`else
  assign viol = tgt_checked & (|next_pc[1:0]);
`endif

  // A new violation always re-arms capture when the flag is being acked in
  // the same cycle; otherwise the first offending target is preserved.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    bad_d      = bad_q;
    if (advance) begin
      pc_d = next_pc;
      if (viol) begin
        misalign_d = 1'b1;
        if (!misalign_q || misalign_ack) bad_d = next_pc;
      end else if (misalign_ack) begin
        misalign_d = 1'b0;
      end
    end
  end

  assign ras_push = advance & is_call & ((pc_sel == SEL_JAL) | (pc_sel == SEL_JALR));
  assign ras_pop  = advance & is_ret & (pc_sel == SEL_JALR) & (cnt_q != '0);

  // Pop+push collapses into an in-place overwrite of the current top entry.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (ras_push && ras_pop) begin
      wr_en  = 1'b1;
      wr_idx = top_q;
    end else if (ras_push) begin
      wr_en  = 1'b1;
      wr_idx = top_q + PTR_ONE;
      top_d  = top_q + PTR_ONE;
      cnt_d  = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CNT_ONE;
    end else if (ras_pop) begin
      top_d = top_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      bad_q      <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bad_q      <= bad_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= pc_plus4;
    end
  end

  assign pc        = pc_q;
  assign misalign  = misalign_q;
  assign bad_addr  = bad_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : stack_q[top_q];

endmodule

// File: tb/tb_otter_pc_unit.sv
// Directed bench for otter_pc_unit: a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points.
module tb_otter_pc_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RVEC  = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic        br_taken = 1'b0;
  logic [31:0] rs1 = '0, i_imm = '0, b_imm = '0, j_imm = '0, mtvec = '0, mepc = '0;
  logic        is_call = 1'b0, is_ret = 1'b0, misalign_ack = 1'b0;
  logic [31:0] pc, pc_plus4, bad_addr, ras_top;
  logic        misalign, ras_empty;

  int n_checks = 0;
  int n_fail   = 0;

  otter_pc_unit #(.XLEN(XLEN), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .pc_sel(pc_sel),
    .br_taken(br_taken), .rs1(rs1), .i_imm(i_imm), .b_imm(b_imm),
    .j_imm(j_imm), .mtvec(mtvec), .mepc(mepc), .is_call(is_call),
    .is_ret(is_ret), .misalign_ack(misalign_ack), .pc(pc),
    .pc_plus4(pc_plus4), .misalign(misalign), .bad_addr(bad_addr),
    .ras_top(ras_top), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] m_pc, m_bad;
  logic        m_mis;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] tgt;
    logic        checked, bad, push, pop;
    if (!rst_n) begin
      m_pc  = RVEC;
      m_mis = 1'b0;
      m_bad = '0;
      m_ras.delete();
    end else if (advance) begin
      checked = 1'b0;
      case (pc_sel)
        3'd1: begin tgt = m_pc + j_imm; checked = 1'b1; end
        3'd2: begin
          tgt = br_taken ? m_pc + b_imm : m_pc + 32'd4;
          checked = br_taken;
        end
        3'd3: begin tgt = (rs1 + i_imm) & 32'hFFFF_FFFE; checked = 1'b1; end
        3'd4: tgt = mtvec & 32'hFFFF_FFFC;
        3'd5: tgt = mepc;
        default: tgt = m_pc + 32'd4;
      endcase
`ifdef OTTER_RVC_EN
      bad = checked && (tgt % 2 != 0);
`else
      bad = checked && (tgt % 4 != 0);
`endif
      if (bad) begin
        if (!m_mis || misalign_ack) m_bad = tgt;
        m_mis = 1'b1;
      end else if (misalign_ack) begin
        m_mis = 1'b0;
      end
      push = is_call && (pc_sel == 3'd1 || pc_sel == 3'd3);
      pop  = is_ret && pc_sel == 3'd3 && m_ras.size() > 0;
      if (pop) void'(m_ras.pop_back());
      if (push) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = tgt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmp_pc", pc, m_pc);
    chk("cmp_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("cmp_misalign", {31'd0, misalign}, {31'd0, m_mis});
    chk("cmp_bad_addr", bad_addr, m_bad);
    chk("cmp_ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    chk("cmp_ras_top", ras_top, (m_ras.size() == 0) ? 32'd0 : m_ras[$]);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic jalr_to(input logic [31:0] a);
    pc_sel = 3'd3; rs1 = a; i_imm = '0;
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset_pc", pc, 32'h100);
    chk("reset_misalign", {31'd0, misalign}, 32'd0);
    chk("reset_ras_empty", {31'd0, ras_empty}, 32'd1);
    chk("reset_ras_top", ras_top, 32'd0);
    chk("reset_bad_addr", bad_addr, 32'd0);

    // Sequential with a stall cycle
    advance = 1'b1; pc_sel = 3'd0; cyc(); chk("seq1", pc, 32'h104);
    advance = 1'b0; cyc(); chk("stall", pc, 32'h104);
    advance = 1'b1; cyc(); chk("seq2", pc, 32'h108);
    chk("seq2_plus4", pc_plus4, 32'h10C);

    // jalr alignment and sticky capture
    pc_sel = 3'd3; rs1 = 32'h2001; i_imm = 32'h10; cyc();
    chk("jalr_ok_pc", pc, 32'h2010); chk("jalr_ok_mis", {31'd0, misalign}, 32'd0);
    rs1 = 32'h2003; cyc();
    chk("jalr_bad_pc", pc, 32'h2012); chk("jalr_bad_mis", {31'd0, misalign}, 32'd1);
    chk("jalr_bad_addr", bad_addr, 32'h2012);
    rs1 = 32'h3003; cyc();
    chk("sticky_pc", pc, 32'h3012); chk("sticky_addr", bad_addr, 32'h2012);
    misalign_ack = 1'b1; rs1 = 32'h4003; cyc();
    chk("race_mis", {31'd0, misalign}, 32'd1); chk("race_addr", bad_addr, 32'h4012);
    pc_sel = 3'd0; cyc();
    chk("ack_mis", {31'd0, misalign}, 32'd0); chk("ack_pc", pc, 32'h4016);
    misalign_ack = 1'b0;
    advance = 1'b0; pc_sel = 3'd3; rs1 = 32'h5003; cyc();
    chk("stall_viol_pc", pc, 32'h4016); chk("stall_viol_mis", {31'd0, misalign}, 32'd0);
    advance = 1'b1;

    // Branches
    jalr_to(32'h200);
    pc_sel = 3'd2; b_imm = 32'hFFFF_FFF8; br_taken = 1'b1; cyc();
    chk("br_taken", pc, 32'h1F8);
    jalr_to(32'h200);
    pc_sel = 3'd2; br_taken = 1'b0; cyc();
    chk("br_not_taken", pc, 32'h204);
    b_imm = 32'h2; br_taken = 1'b1; cyc();
    chk("br_bad_mis", {31'd0, misalign}, 32'd1); chk("br_bad_addr", bad_addr, 32'h206);
    misalign_ack = 1'b1; pc_sel = 3'd0; cyc(); misalign_ack = 1'b0;
    chk("br_ack_pc", pc, 32'h20A);
    pc_sel = 3'd2; br_taken = 1'b0; cyc();
    chk("br_nt_unchecked", {31'd0, misalign}, 32'd0); chk("br_nt_pc", pc, 32'h20E);

    // jal, trap, mret, reserved selects
    pc_sel = 3'd1; j_imm = 32'h12; cyc(); chk("jal_pc", pc, 32'h220);
    j_imm = 32'h1; cyc();
    chk("jal_bad_mis", {31'd0, misalign}, 32'd1); chk("jal_bad_addr", bad_addr, 32'h221);
    misalign_ack = 1'b1; pc_sel = 3'd4; mtvec = 32'h8003; cyc(); misalign_ack = 1'b0;
    chk("trap_pc", pc, 32'h8000); chk("trap_mis", {31'd0, misalign}, 32'd0);
    pc_sel = 3'd5; mepc = 32'h9002; cyc();
    chk("mret_pc", pc, 32'h9002); chk("mret_mis", {31'd0, misalign}, 32'd0);
    pc_sel = 3'd6; cyc(); chk("sel6", pc, 32'h9006);
    pc_sel = 3'd7; cyc(); chk("sel7", pc, 32'h900A);

    // Address wrap
    jalr_to(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    pc_sel = 3'd0; cyc(); chk("wrap_pc", pc, 32'h0);

    // Return-address stack
    jalr_to(32'h10);
    pc_sel = 3'd1; j_imm = 32'h10; is_call = 1'b1;
    repeat (5) cyc();
    chk("ras_full_top", ras_top, 32'h54); chk("ras_full_pc", pc, 32'h60);
    pc_sel = 3'd4; mtvec = 32'h100; cyc(); chk("trap_no_push", ras_top, 32'h54);
    pc_sel = 3'd0; cyc(); chk("seq_no_push", ras_top, 32'h54);
    is_call = 1'b0;
    pc_sel = 3'd3; rs1 = 32'h400; i_imm = '0; is_ret = 1'b1;
    cyc(); chk("ret1", ras_top, 32'h44);
    cyc(); chk("ret2", ras_top, 32'h34);
    cyc(); chk("ret3", ras_top, 32'h24);
    cyc(); chk("ret4_empty", {31'd0, ras_empty}, 32'd1); chk("ret4_top", ras_top, 32'd0);
    cyc(); chk("ret5_empty", {31'd0, ras_empty}, 32'd1);
    is_call = 1'b1; rs1 = 32'h500; cyc();
    chk("callret_empty_top", ras_top, 32'h404);
    rs1 = 32'h600; cyc();
    chk("callret_top", ras_top, 32'h504);
    is_call = 1'b0; cyc();
    chk("callret_count", {31'd0, ras_empty}, 32'd1);
    is_ret = 1'b0;
    advance = 1'b0; is_call = 1'b1; pc_sel = 3'd1; cyc();
    chk("stall_no_push", {31'd0, ras_empty}, 32'd1);
    advance = 1'b1; j_imm = 32'h10; cyc();
    chk("call_top", ras_top, 32'h604);
    is_call = 1'b0; pc_sel = 3'd3; rs1 = 32'h703; cyc();
    chk("pre_reset_mis", {31'd0, misalign}, 32'd1);

    // Asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h100);
    chk("async_mis", {31'd0, misalign}, 32'd0);
    chk("async_empty", {31'd0, ras_empty}, 32'd1);
    chk("async_top", ras_top, 32'd0);
    chk("async_bad", bad_addr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1; pc_sel = 3'd0;
    cyc(); chk("post_reset_pc", pc, 32'h104);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
